// File: rtl/word_sender_pkg.sv
// Shared types and constants for the word_sender transmit path.
package word_sender_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    HOLD
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  // The checksum byte follows the last data byte.
  localparam int CHECKSUM_IDX   = BYTES_PER_WORD;

endpackage

// File: rtl/word_fifo.sv
// Word FIFO, 2**DEPTH_LOG2 entries; head word visible combinationally on pop_data.
// Pushes while full are dropped even if a pop happens the same cycle.
module word_fifo #(
  parameter int DEPTH_LOG2 = 2,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      pop_data,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full     = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && (count != '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (DEPTH_LOG2+1)'(1);
        2'b01:   count <= count - (DEPTH_LOG2+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/word_sender.sv
// Buffers 32-bit words and sends each MSB-first as bytes to the UART TX; first tx_start 2 cycles after push.
// Optional WORD_SENDER_CHECKSUM_EN appends an XOR checksum byte; waits on tx_busy before every byte.
module word_sender
  import word_sender_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        idle
);

`ifdef WORD_SENDER_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'(CHECKSUM_IDX);
`else
  localparam logic [2:0] LAST_IDX = 3'(BYTES_PER_WORD - 1);
`endif

  state_t              state_q;
  state_t              state_d;
  logic [31:0]         shift_q;
  logic [2:0]          byte_idx;
  logic [31:0]         fifo_data;
  logic                fifo_full;
  logic [DEPTH_LOG2:0] fifo_count;
  logic                fifo_pop;
  logic                load;
  logic                send;
  logic                advance;
  logic [7:0]          cur_byte;

  word_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .WIDTH     (32)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (in_valid),
    .push_data(in_data),
    .pop      (fifo_pop),
    .pop_data (fifo_data),
    .full     (fifo_full),
    .count    (fifo_count)
  );

  assign in_ready = !fifo_full;
  assign idle     = (state_q == IDLE) && (fifo_count == '0);

`ifdef WORD_SENDER_CHECKSUM_EN
  logic [7:0] chk_q;
  // Running XOR of the data bytes already sent is the checksum by the last slot.
  assign cur_byte = (byte_idx == LAST_IDX) ? chk_q : shift_q[31:24];

  always_ff @(posedge clk) begin
    if (reset || load) begin
      chk_q <= 8'h00;
    end else if (send) begin
      chk_q <= chk_q ^ shift_q[31:24];
    end
  end
`else
  assign cur_byte = shift_q[31:24];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    load     = 1'b0;
    send     = 1'b0;
    advance  = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_count != '0) begin
          fifo_pop = 1'b1;
          load     = 1'b1;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          send    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // tx_busy is not yet valid here; the transmitter raises it one cycle late.
        advance = (byte_idx != LAST_IDX);
        state_d = advance ? SEND : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q  <= '0;
      byte_idx <= '0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      tx_start <= send;
      if (load) begin
        shift_q  <= fifo_data;
        byte_idx <= '0;
      end
      if (send) begin
        tx_data <= cur_byte;
        shift_q <= {shift_q[23:0], 8'h00};
      end
      if (advance) begin
        byte_idx <= byte_idx + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_word_sender.sv
// Directed bench for word_sender with a simple UART busy model and byte log.
module tb_word_sender;

`ifdef WORD_SENDER_CHECKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        idle;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          busy_len;
  int          busy_cnt = 0;
  logic        force_busy;
  logic [7:0]  byte_log [$];
  int          pulse_cyc [$];
  int          push_edge;

  word_sender #(.DEPTH_LOG2(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .tx_busy (tx_busy),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .idle    (idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign tx_busy = force_busy || (busy_cnt != 0);

  // Transmitter model: log each pulse and stay busy for busy_len cycles.
  always @(negedge clk) begin
    if (!reset && tx_start) begin
      byte_log.push_back(tx_data);
      pulse_cyc.push_back(cyc);
      busy_cnt = busy_len;
    end else if (busy_cnt != 0) begin
      busy_cnt = busy_cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [7:0] exp_byte(input logic [31:0] w, input int i);
    if (i < 4) return w[31-8*i -: 8];
    return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction

  task automatic push_word(input logic [31:0] w);
    int t = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) check("push_timeout", 32'd1, 32'd0);
    @(negedge clk);
    push_edge = cyc;
    in_valid  = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int t = 0;
    while (!idle && t < max_cyc) begin
      @(negedge clk);
      t++;
    end
    if (t >= max_cyc) check("idle_timeout", 32'd1, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_words(input string tag, input logic [31:0] w [$]);
    check({tag, "_nbytes"}, byte_log.size(), w.size() * NB);
    for (int k = 0; k < w.size(); k++) begin
      for (int i = 0; i < NB; i++) begin
        if (k*NB + i < byte_log.size())
          check(tag, {24'h0, byte_log[k*NB + i]}, {24'h0, exp_byte(w[k], i)});
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] words [$];
    int acc;

    reset = 1'b1; in_valid = 1'b0; in_data = '0;
    force_busy = 1'b0; busy_len = 10;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_idle", idle, 1);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 8'h00);
    reset = 1'b0;
    @(negedge clk);

    // Single word, slow transmitter.
    byte_log.delete();
    push_word(32'h12345678);
    wait_idle(1000);
    check_words("single", '{32'h12345678});
    if (NB == 5 && byte_log.size() == 5) check("single_chk", byte_log[4], 8'h08);
    check("single_idle", idle, 1);

    // Stall the transmitter with one word in flight, then overfill the FIFO.
    byte_log.delete();
    force_busy = 1'b1;
    push_word(32'h0A0B0C0D);
    repeat (3) @(negedge clk);
    words = '{32'h10203040, 32'h50607080, 32'h90A0B0C0, 32'hD0E0F001,
              32'h55555555, 32'h66666666};
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = words[i];
      if (in_ready) acc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("full_accepted", acc, 4);
    check("full_in_ready", in_ready, 0);
    check("full_no_tx", byte_log.size(), 0);
    force_busy = 1'b0;
    busy_len = 3;
    wait_idle(2000);
    check_words("full", '{32'h0A0B0C0D, 32'h10203040, 32'h50607080,
                          32'h90A0B0C0, 32'hD0E0F001});
    check("full_ready_after", in_ready, 1);

    // All-ones word is ordinary data.
    byte_log.delete();
    push_word(32'hFFFFFFFF);
    wait_idle(1000);
    check_words("ones", '{32'hFFFFFFFF});
    if (NB == 5 && byte_log.size() == 5) check("ones_chk", byte_log[4], 8'h00);

    // Never-busy transmitter: pulse timing.
    repeat (15) @(negedge clk);
    busy_len = 0;
    byte_log.delete();
    pulse_cyc.delete();
    push_word(32'hCAFEF00D);
    wait_idle(200);
    check_words("fast", '{32'hCAFEF00D});
    if (pulse_cyc.size() > 0) check("fast_first", pulse_cyc[0] - push_edge, 2);
    for (int i = 1; i < pulse_cyc.size(); i++)
      check("fast_spacing", pulse_cyc[i] - pulse_cyc[i-1], 2);

    // Reset after the first byte of a word.
    busy_len = 10;
    byte_log.delete();
    push_word(32'hAABBCCDD);
    begin
      int t = 0;
      while (byte_log.size() < 1 && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) check("mid_timeout", 32'd1, 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    check("mid_tx_start", tx_start, 0);
    check("mid_idle", idle, 1);
    check("mid_in_ready", in_ready, 1);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("mid_no_more", byte_log.size(), 1);
    if (byte_log.size() > 0) check("mid_first", byte_log[0], 8'hAA);
    byte_log.delete();
    push_word(32'h01020304);
    wait_idle(1000);
    check_words("after_rst", '{32'h01020304});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/word_sender.md
# word_sender

Transmit-side counterpart of the host loader. It accepts 32-bit words from the core (result/output port), buffers them in a small FIFO and serializes each word MSB-first into bytes for the UART transmitter. The byte order and framing match what the host-to-core loader consumes, so host tooling uses one word format in both directions. It sits between the core's output port and the UART TX byte interface.

## Interface
- DEPTH_LOG2, 2, FIFO depth = 2**DEPTH_LOG2 words
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clock clk
- in_valid  in  1  core presents in_data this cycle
- in_data  in  32  word to send
- in_ready  out  1  FIFO not full; push occurs when in_valid && in_ready
- tx_busy  in  1  UART transmitter busy; goes high the cycle after tx_start, low when the byte has left
- tx_start  out  1  one-cycle pulse: transmitter latches tx_data
- tx_data  out  8  byte to transmit, valid while tx_start=1
- idle  out  1  FIFO empty and FSM in IDLE

## Operation
- FIFO: DEPTH_LOG2-bit read/write pointers plus (DEPTH_LOG2+1)-bit count; pointers wrap modulo depth.
- in_ready = (count != depth), combinational from count only; push while full is ignored even if a pop occurs the same cycle.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- FSM states: IDLE, SEND, HOLD.
  - IDLE: if count != 0, pop head into 32-bit shift register, byte index <= 0, -> SEND.
  - SEND: if tx_busy == 0, register tx_start <= 1, tx_data <= current byte (index 0 = bits 31:24, then 23:16, 15:8, 7:0), -> HOLD; else stay, tx_start = 0.
  - HOLD: tx_start <= 0; one cycle ignoring tx_busy (covers transmitter's one-cycle busy latency). If last byte sent -> IDLE, else index+1 -> SEND.
- Bytes per word: 4 (5 with checksum, see Configuration).
- Word 0xFFFFFFFF has no special meaning here; sent as plain data (host interprets it).
- idle = (state == IDLE) && (count == 0).

## Timing
- Reset values: in_ready=1, tx_start=0, tx_data=8'h00, idle=1, count=0, pointers=0, state IDLE.
- Reset mid-word: FSM to IDLE, FIFO flushed, tx_start=0 next cycle; byte already on the line finishes inside the transmitter, remaining bytes dropped.
- Latency: word pushed at edge N into empty FIFO, tx_busy=0 -> popped at edge N+1, tx_start=1 after edge N+2.
- Byte spacing with transmitter always idle: tx_start pulses every 2 cycles (SEND, HOLD).
- Never two tx_start pulses without an intervening SEND check of tx_busy == 0.
- tx_data holds its last value between pulses.

## Configuration
- WORD_SENDER_CHECKSUM_EN defined: after byte 3, a fifth byte = in_data[31:24] ^ [23:16] ^ [15:8] ^ [7:0] is sent with the same SEND/HOLD handshake; last-byte index = 4.
- Undefined: exactly 4 bytes per word, no checksum logic or register.

## Structure
- Package word_sender_pkg: state enum (IDLE, SEND, HOLD), BYTES_PER_WORD = 4, checksum byte index constant.
- Sub-module word_fifo (parameter DEPTH_LOG2, width 32): push/pop, full/empty, count; word_sender instantiates it and owns FSM, shift register, checksum.

## Test plan
- Reset: hold reset 3 cycles -> in_ready=1, idle=1, tx_start=0, tx_data=8'h00.
- Single word 0x12345678, tx_busy model 10 cycles per byte -> tx_data sequence 12,34,56,78; with WORD_SENDER_CHECKSUM_EN additionally 08; idle=1 afterwards.
- tx_busy held high, push 6 words with in_valid=1 -> exactly 4 accepted (DEPTH_LOG2=2), in_ready=0 after 4th; release tx_busy -> all 4 words sent in order, no loss or duplication.
- Push 0xFFFFFFFF -> four bytes FF sent (checksum 00 if enabled), no mode effect.
- Transmitter always idle (tx_busy=0 model that never asserts) -> tx_start spacing exactly 2 cycles; first pulse 2 cycles after push edge.
- Reset asserted after byte 1 of 0xAABBCCDD -> no further tx_start, FIFO empty, next word 0x01020304 sent cleanly as 01,02,03,04.
